// File: rtl/traffic_pkg.sv
// Shared light codes and scheduler state encoding for the
// farm-road crossing controllers.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b001;
  localparam logic [2:0] LIGHT_GREEN  = 3'b010;
  localparam logic [2:0] LIGHT_YELLOW = 3'b011;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ARB        = 3'd1;
  localparam logic [2:0] S_WAIT_GREEN = 3'd2;
  localparam logic [2:0] S_SERVE      = 3'd3;
  localparam logic [2:0] S_WAIT_CLEAR = 3'd4;

endpackage

// File: rtl/request_scheduler_rr_picker.sv
// Combinational round-robin picker: first set request at or
// above the pointer, wrapping modulo N.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic          found;
    logic [IW-1:0] j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int off = 0; off < N; off++) begin
      j = IW'((int'(ptr) + off) % N);
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/request_scheduler.sv
// Round-robin owner of the farm-road right-of-way; drives the
// light controller's sen and tracks its farmroad light code.
import traffic_pkg::*;

module request_scheduler #(
  parameter int N         = 4,
  parameter int MAX_SERVE = 8,
  parameter int TIMEOUT   = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic [2:0]   farmroad,
  output logic         sen,
  output logic [N-1:0] grant,
  output logic [N-1:0] pending,
  output logic         busy,
  output logic         err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = (MAX_SERVE > 1) ? $clog2(MAX_SERVE) : 1;
  localparam int WW = $clog2(TIMEOUT);

  logic [2:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gidx;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick;
  logic [N-1:0]  clr;
  logic [SW-1:0] sc;
  logic [WW-1:0] wd;
  logic          green;
  logic          red;

  rr_picker #(.N(N), .IW(IW)) u_pick (
    .req  (pending),
    .ptr  (ptr),
    .grant(pick),
    .idx  (pick_idx)
  );

  assign green = (farmroad == LIGHT_GREEN);
  assign red   = (farmroad == LIGHT_RED);
  assign busy  = (state != S_IDLE);
  assign clr   = (state == S_WAIT_GREEN && green) ? grant : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      ptr     <= '0;
      gidx    <= '0;
      grant   <= '0;
      pending <= '0;
      sen     <= 1'b0;
      err     <= 1'b0;
      sc      <= '0;
      wd      <= '0;
    end else begin
      // a fresh request wins over the clear of its own bit
      pending <= (pending & ~clr) | req;
      unique case (state)
        S_IDLE: begin
          if (|pending) state <= S_ARB;
        end
        S_ARB: begin
          grant <= pick;
          gidx  <= pick_idx;
          sen   <= 1'b1;
          wd    <= '0;
          state <= S_WAIT_GREEN;
        end
        S_WAIT_GREEN: begin
          if (green) begin
            sc    <= '0;
            state <= S_SERVE;
          end else if (wd == WW'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            sen   <= 1'b0;
            state <= S_WAIT_CLEAR;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_SERVE: begin
          if (sc == SW'(MAX_SERVE - 1)) begin
            sen   <= 1'b0;
            state <= S_WAIT_CLEAR;
          end else begin
            sc <= sc + 1'b1;
          end
        end
        S_WAIT_CLEAR: begin
          if (red) begin
            grant <= '0;
            ptr   <= (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_request_scheduler.sv
// Directed bench for request_scheduler with a simple light
// controller model that greens a few cycles after sen.
import traffic_pkg::*;

module tb_request_scheduler;

  localparam int N  = 4;
  localparam int MS = 8;
  localparam int TO = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [2:0]   farmroad = LIGHT_RED;
  logic         sen;
  logic [N-1:0] grant;
  logic [N-1:0] pending;
  logic         busy;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;
  int lcnt = 0;
  int gdelay = 3;
  bit never_green = 1'b0;

  request_scheduler #(.N(N), .MAX_SERVE(MS), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .farmroad(farmroad),
    .sen     (sen),
    .grant   (grant),
    .pending (pending),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  // light controller model, updates on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      farmroad = LIGHT_RED;
      lcnt = 0;
    end else begin
      case (farmroad)
        LIGHT_RED: begin
          if (sen && !never_green) begin
            lcnt++;
            if (lcnt >= gdelay) farmroad = LIGHT_GREEN;
          end else begin
            lcnt = 0;
          end
        end
        LIGHT_GREEN: if (!sen) farmroad = LIGHT_YELLOW;
        default: begin
          farmroad = LIGHT_RED;
          lcnt = 0;
        end
      endcase
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // req driven for exactly one rising edge; returns half a cycle after it
  task automatic pulse(input logic [N-1:0] r);
    @(negedge clk);
    req = r;
    @(negedge clk);
    req = '0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (grant != '0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_release(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (grant == '0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_pending(input logic [N-1:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (pending == v) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({sen, grant, pending, busy, err} !== '0) begin
      n_bad++;
      $display("FAIL reset_vals: got sen=%b grant=%b pend=%b busy=%b err=%b want all 0",
               sen, grant, pending, busy, err);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if ({sen, grant, busy} !== '0) begin
      n_bad++;
      $display("FAIL idle_quiet: got sen=%b grant=%b busy=%b want 0", sen, grant, busy);
    end
  endtask

  task automatic test_single();
    int cnt;
    bit ok;
    do_reset();
    gdelay = 3;
    pulse(4'b0010);
    n_cmp++;
    if (pending !== 4'b0010 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_capture: got pend=%b busy=%b want 0010/0", pending, busy);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (grant !== 4'b0000 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_arb: got grant=%b busy=%b want 0000/1", grant, busy);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (grant !== 4'b0010 || sen !== 1'b1) begin
      n_bad++;
      $display("FAIL single_grant: got grant=%b sen=%b want 0010/1", grant, sen);
    end
    cnt = 0;
    while (sen === 1'b1 && cnt < 100) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (cnt != 3 + MS) begin
      n_bad++;
      $display("FAIL single_sen_len: got %0d want %0d", cnt, 3 + MS);
    end
    n_cmp++;
    if (grant !== 4'b0010 || pending !== 4'b0000) begin
      n_bad++;
      $display("FAIL single_hold: got grant=%b pend=%b want 0010/0000", grant, pending);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_red_clear: got grant=%b busy=%b want 0000/0", grant, busy);
    end
    wait_release(ok);
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_g;
    logic [N-1:0] left;
    bit ok;
    do_reset();
    pulse(4'b1111);
    left = 4'b1111;
    for (int i = 0; i < N; i++) begin
      exp_g = 4'b0001 << i;
      wait_grant(ok);
      n_cmp++;
      if (!ok || grant !== exp_g || pending !== left) begin
        n_bad++;
        $display("FAIL fair_grant%0d: got grant=%b pend=%b want %b/%b",
                 i, grant, pending, exp_g, left);
      end
      left = left & ~exp_g;
      wait_release(ok);
      n_cmp++;
      if (!ok || pending !== left) begin
        n_bad++;
        $display("FAIL fair_clear%0d: got pend=%b want %b", i, pending, left);
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    pulse(4'b0100);
    wait_grant(ok);
    pulse(4'b1001);
    n_cmp++;
    if (grant !== 4'b0100 || pending[3] !== 1'b1 || pending[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_setup: got grant=%b pend=%b want 0100/1x01", grant, pending);
    end
    wait_release(ok);
    wait_grant(ok);
    n_cmp++;
    if (!ok || grant !== 4'b1000) begin
      n_bad++;
      $display("FAIL wrap_first: got %b want 1000", grant);
    end
    wait_release(ok);
    wait_grant(ok);
    n_cmp++;
    if (!ok || grant !== 4'b0001) begin
      n_bad++;
      $display("FAIL wrap_second: got %b want 0001", grant);
    end
    wait_release(ok);
  endtask

  task automatic test_rerequest();
    bit ok;
    do_reset();
    pulse(4'b0101);
    wait_grant(ok);
    n_cmp++;
    if (!ok || grant !== 4'b0001) begin
      n_bad++;
      $display("FAIL rereq_first: got %b want 0001", grant);
    end
    wait_pending(4'b0100, ok);
    pulse(4'b0001);
    n_cmp++;
    if (!ok || pending !== 4'b0101 || grant !== 4'b0001) begin
      n_bad++;
      $display("FAIL rereq_rearm: got pend=%b grant=%b want 0101/0001", pending, grant);
    end
    wait_release(ok);
    wait_grant(ok);
    n_cmp++;
    if (!ok || grant !== 4'b0100) begin
      n_bad++;
      $display("FAIL rereq_other: got %b want 0100", grant);
    end
    wait_release(ok);
    wait_grant(ok);
    n_cmp++;
    if (!ok || grant !== 4'b0001) begin
      n_bad++;
      $display("FAIL rereq_again: got %b want 0001", grant);
    end
    wait_release(ok);
  endtask

  task automatic test_timeout();
    int cnt;
    bit ok;
    do_reset();
    never_green = 1'b1;
    pulse(4'b0010);
    wait_grant(ok);
    cnt = 0;
    while (sen === 1'b1 && cnt < 100) begin
      n_cmp++;
      if (err !== 1'b0) begin
        n_bad++;
        $display("FAIL to_early_err: got err=%b at %0d want 0", err, cnt);
      end
      cnt++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (cnt != TO || err !== 1'b1) begin
      n_bad++;
      $display("FAIL to_err: got cycles=%0d err=%b want %0d/1", cnt, err, TO);
    end
    n_cmp++;
    if (pending !== 4'b0010 || grant !== 4'b0010) begin
      n_bad++;
      $display("FAIL to_keep: got pend=%b grant=%b want 0010/0010", pending, grant);
    end
    never_green = 1'b0;
    wait_release(ok);
    wait_grant(ok);
    n_cmp++;
    if (!ok || grant !== 4'b0010) begin
      n_bad++;
      $display("FAIL to_retry: got %b want 0010", grant);
    end
    wait_release(ok);
    n_cmp++;
    if (!ok || pending !== 4'b0000 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL to_sticky: got pend=%b err=%b want 0000/1", pending, err);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    pulse(4'b0011);
    wait_grant(ok);
    pulse(4'b0100);
    wait_pending(4'b0110, ok);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({sen, grant, pending, busy, err} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got sen=%b grant=%b pend=%b busy=%b err=%b want 0",
               sen, grant, pending, busy, err);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (grant !== 4'b0000 || sen !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_quiet: got grant=%b sen=%b want 0000/0", grant, sen);
    end
    pulse(4'b0100);
    wait_grant(ok);
    n_cmp++;
    if (!ok || grant !== 4'b0100) begin
      n_bad++;
      $display("FAIL mid_new: got %b want 0100", grant);
    end
    wait_release(ok);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_rerequest();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
